// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encodings,
// register address width and the bundled stall/flush control word.
package pipeline_hazard_ctrl_pkg;

  localparam int unsigned RegAddrW = 5;

  typedef enum logic [1:0] {
    StRun      = 2'd0,
    StExcFlush = 2'd1,
    StMemWait  = 2'd2
  } hazard_state_e;

  typedef struct packed {
    logic pc_stall;
    logic ifid_stall;
    logic ifid_flush;
    logic idex_stall;
    logic idex_flush;
    logic exmem_stall;
    logic exmem_flush;
    logic memwb_stall;
    logic memwb_flush;
  } hazard_ctl_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Datapath <-> hazard controller bundle: stage hazard inputs in, stall/flush controls out.
interface pipeline_hazard_ctrl_if;
  import pipeline_hazard_ctrl_pkg::*;

  logic [RegAddrW-1:0] id_rs1_addr;
  logic [RegAddrW-1:0] id_rs2_addr;
  logic                id_rs1_used;
  logic                id_rs2_used;
  logic [RegAddrW-1:0] ex_waddr;
  logic                ex_we;
  logic                ex_mem_load;
  logic                ex_branch_taken;
  logic                ex_md_busy;
  logic                if_imem_wait;
  logic                mem_dmem_wait;
  logic                mem_exception;

  logic                pc_stall;
  logic                ifid_stall;
  logic                ifid_flush;
  logic                idex_stall;
  logic                idex_flush;
  logic                exmem_stall;
  logic                exmem_flush;
  logic                memwb_stall;
  logic                memwb_flush;
  logic                exc_redirect;
  logic                bus_timeout;
  logic [31:0]         stall_count;

  modport master (
    output id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
    output ex_waddr, ex_we, ex_mem_load, ex_branch_taken, ex_md_busy,
    output if_imem_wait, mem_dmem_wait, mem_exception,
    input  pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
    input  exmem_stall, exmem_flush, memwb_stall, memwb_flush,
    input  exc_redirect, bus_timeout, stall_count
  );

  modport slave (
    input  id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
    input  ex_waddr, ex_we, ex_mem_load, ex_branch_taken, ex_md_busy,
    input  if_imem_wait, mem_dmem_wait, mem_exception,
    output pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
    output exmem_stall, exmem_flush, memwb_stall, memwb_flush,
    output exc_redirect, bus_timeout, stall_count
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Load-use hazard comparator: a load in EX whose destination is read by the ID instruction.
module pipeline_hazard_ctrl_load_use_detect
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [RegAddrW-1:0] i_rs1_addr,
  input  logic [RegAddrW-1:0] i_rs2_addr,
  input  logic                i_rs1_used,
  input  logic                i_rs2_used,
  input  logic [RegAddrW-1:0] i_ex_waddr,
  input  logic                i_ex_we,
  input  logic                i_ex_load,
  output logic                o_hit
);

  logic w_rs1_hit;
  logic w_rs2_hit;

  assign w_rs1_hit = i_rs1_used && (i_rs1_addr == i_ex_waddr);
  assign w_rs2_hit = i_rs2_used && (i_rs2_addr == i_ex_waddr);

  // x0 is never a real dependency
  assign o_hit = i_ex_load && i_ex_we && (i_ex_waddr != '0) && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush arbiter for the 5-stage pipeline, with exception flush sequencing,
// a dmem-wait watchdog and a pc-stall cycle counter.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned ExcFlushCycles = 2,
  parameter int unsigned MemTimeout     = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_hazard_ctrl_if.slave bus
);

  localparam int unsigned WaitCntW = $clog2(MemTimeout + 2);
  localparam int unsigned ExcCntW  = $clog2(ExcFlushCycles + 1);
  localparam int unsigned ExcLoad  = (ExcFlushCycles > 1) ? ExcFlushCycles - 2 : 0;

  hazard_state_e       r_state;
  logic [WaitCntW-1:0] r_wait_cnt;
  logic [ExcCntW-1:0]  r_exc_cnt;
  logic [31:0]         r_stall_count;

  hazard_ctl_t w_ctl;
  logic        w_exc_redirect;
  logic        w_bus_timeout;
  logic        w_load_use;

  pipeline_hazard_ctrl_load_use_detect u_load_use_detect (
    .i_rs1_addr (bus.id_rs1_addr),
    .i_rs2_addr (bus.id_rs2_addr),
    .i_rs1_used (bus.id_rs1_used),
    .i_rs2_used (bus.id_rs2_used),
    .i_ex_waddr (bus.ex_waddr),
    .i_ex_we    (bus.ex_we),
    .i_ex_load  (bus.ex_mem_load),
    .o_hit      (w_load_use)
  );

  // Branch sits above load-use: the ID instruction is wrong-path once a branch redirects.
  always_comb begin
    w_ctl          = '0;
    w_exc_redirect = 1'b0;
    w_bus_timeout  = 1'b0;
    if (!rst) begin
      w_ctl.ifid_flush  = 1'b1;
      w_ctl.idex_flush  = 1'b1;
      w_ctl.exmem_flush = 1'b1;
      w_ctl.memwb_flush = 1'b1;
    end else if (r_state == StExcFlush) begin
      w_ctl.ifid_flush = 1'b1;
      w_ctl.idex_flush = 1'b1;
    end else if (bus.mem_exception) begin
      w_ctl.ifid_flush  = 1'b1;
      w_ctl.idex_flush  = 1'b1;
      w_ctl.exmem_flush = 1'b1;
      w_ctl.memwb_flush = 1'b1;
      w_exc_redirect    = 1'b1;
    end else if (bus.mem_dmem_wait) begin
      w_ctl.pc_stall    = 1'b1;
      w_ctl.ifid_stall  = 1'b1;
      w_ctl.idex_stall  = 1'b1;
      w_ctl.exmem_stall = 1'b1;
      w_ctl.memwb_flush = 1'b1;
      w_bus_timeout     = (r_wait_cnt == WaitCntW'(MemTimeout));
    end else if (bus.ex_md_busy) begin
      w_ctl.pc_stall    = 1'b1;
      w_ctl.ifid_stall  = 1'b1;
      w_ctl.idex_stall  = 1'b1;
      w_ctl.exmem_flush = 1'b1;
    end else if (bus.ex_branch_taken) begin
      w_ctl.ifid_flush = 1'b1;
      w_ctl.idex_flush = 1'b1;
    end else if (w_load_use) begin
      w_ctl.pc_stall   = 1'b1;
      w_ctl.ifid_stall = 1'b1;
      w_ctl.idex_flush = 1'b1;
    end else if (bus.if_imem_wait) begin
      w_ctl.pc_stall   = 1'b1;
      w_ctl.ifid_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= StRun;
      r_wait_cnt    <= '0;
      r_exc_cnt     <= '0;
      r_stall_count <= '0;
    end else begin
      if (w_ctl.pc_stall) begin
        r_stall_count <= r_stall_count + 32'd1;
      end
      case (r_state)
        StExcFlush: begin
          r_wait_cnt <= '0;
          if (r_exc_cnt == '0) begin
            r_state <= StRun;
          end else begin
            r_exc_cnt <= r_exc_cnt - ExcCntW'(1);
          end
        end
        StRun, StMemWait: begin
          if (bus.mem_exception) begin
            r_wait_cnt <= '0;
            r_exc_cnt  <= ExcCntW'(ExcLoad);
            r_state    <= (ExcFlushCycles > 1) ? StExcFlush : StRun;
          end else if (bus.mem_dmem_wait) begin
            r_state <= StMemWait;
            // Saturate one past the threshold so the timeout pulse fires only once
            if (r_wait_cnt != WaitCntW'(MemTimeout + 1)) begin
              r_wait_cnt <= r_wait_cnt + WaitCntW'(1);
            end
          end else begin
            r_state    <= StRun;
            r_wait_cnt <= '0;
          end
        end
        default: begin
          r_state    <= StRun;
          r_wait_cnt <= '0;
        end
      endcase
    end
  end

  assign bus.pc_stall     = w_ctl.pc_stall;
  assign bus.ifid_stall   = w_ctl.ifid_stall;
  assign bus.ifid_flush   = w_ctl.ifid_flush;
  assign bus.idex_stall   = w_ctl.idex_stall;
  assign bus.idex_flush   = w_ctl.idex_flush;
  assign bus.exmem_stall  = w_ctl.exmem_stall;
  assign bus.exmem_flush  = w_ctl.exmem_flush;
  assign bus.memwb_stall  = w_ctl.memwb_stall;
  assign bus.memwb_flush  = w_ctl.memwb_flush;
  assign bus.exc_redirect = w_exc_redirect;
  assign bus.bus_timeout  = w_bus_timeout;
  assign bus.stall_count  = rst ? r_stall_count : 32'd0;

endmodule
